pwm_multi_channel: RTL and testbench
====================================

Name: pwm_multi_channel

Overview:
- Multi-channel PWM generator: CHANNELS outputs share one period counter; each channel has its own duty value.
- Supports edge-aligned and center-aligned modes.
- Period, duty and mode are double-buffered: a load is staged in shadow registers and applied at the period boundary, so no output ever sees a glitch.
- The counter advances only on i_ce ticks, so a prescaler or strobe upstream sets the PWM time base.

Parameters:
- WIDTH, 8, bit width of the counter, period and each duty value.
- CHANNELS, 4, number of independent PWM outputs.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- i_ce  input  1  count enable; the counter advances one step per clk with i_ce=1.
- i_enable  input  1  1 = run, 0 = stop (counter and outputs held at 0).
- i_load  input  1  one-clk strobe; captures i_period, i_duty and i_mode into the shadow registers.
- i_period  input  WIDTH  period value P (meaning depends on mode).
- i_duty  input  CHANNELS*WIDTH  channel k duty D_k in bits [k*WIDTH +: WIDTH].
- i_mode  input  1  0 = edge-aligned, 1 = center-aligned.
- o_pwm  output  CHANNELS  PWM outputs, registered.
- o_period_end  output  1  one-clk pulse when the counter wraps to the period start.
- o_load_pending  output  1  shadow values are waiting to be applied.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - counter=0, state=IDLE.
  - Active and shadow period, duties and mode = 0.
  - o_pwm=0, o_period_end=0, o_load_pending=0.
- States:
  - IDLE: i_enable=0.
  - UP: counting upward.
  - DOWN: counting downward; center mode only.
- IDLE:
  - counter=0, o_pwm=0.
  - Any pending shadow values are copied to active immediately and pending clears.
  - i_enable=1 -> UP with counter=0, on the next clk.
- Edge mode (active mode=0):
  - UP counts 0..P on i_ce ticks, then wraps to 0. Period = P+1 ticks.
  - Compare: high when cnt < D_k. D_k=0 gives 0%; D_k >= P+1 gives 100%.
- Center mode (active mode=1):
  - UP counts 0..P-1, then DOWN counts P..1, then back to UP at 0. Period = 2P ticks.
  - Compare in UP: high when cnt < D_k. Compare in DOWN: high when cnt <= D_k.
  - High time = 2*min(D_k,P) ticks; the high pulse is symmetric about the wrap point.
  - P=0: counter held at 0; output high iff D_k != 0; boundary occurs on every i_ce tick.
- Output timing:
  - o_pwm[k] is registered: it reflects the compare on the (state, counter) present in the previous clk.
  - It is updated every clk, independent of i_ce.
- Boundary:
  - Occurs on the i_ce tick that returns the counter to 0 / UP.
  - o_period_end pulses in the clk after that tick, aligned with the o_pwm of the new period.
- Shadow load:
  - i_load captures the inputs into shadow and sets o_load_pending in the next clk.
  - At the next boundary, shadow is copied to active and pending clears in the same clk.
  - The new period starts with the new values; a mode change restarts at UP with counter=0.
- i_load coinciding with a boundary: the just-presented values are applied at that boundary (bypass); pending stays 0.
- Multiple i_load strobes before a boundary: the last one wins.
- i_ce=0: counter and state frozen; o_pwm holds its compare result.
- i_enable falling mid-period: next clk goes to IDLE, counter=0; o_pwm=0 one clk later.
- Active-low reset asserted mid-operation overrides everything and takes effect in the same clk.
- Arithmetic: all comparisons are unsigned WIDTH-bit; the counter never exceeds P, so no overflow occurs.

Test Plan:
- Reset, then WIDTH=8, i_ce=1, load P=9, D0=3, mode=0, enable -> o_pwm[0] high 3 of every 10 clks; o_period_end pulses every 10 clks.
- Edge boundaries: D1=0, D2=10, D3=255 with P=9 -> o_pwm[1] constant 0; o_pwm[2] and o_pwm[3] constant 1.
- Center mode, P=8, D0=3 -> o_pwm[0] high 6 of every 16 clks: 3 clks before and 3 clks after each o_period_end-aligned wrap. D0=8 -> constant 1.
- Mid-period load while running P=9, D0=3 (mode 0); load D0=7 at cycle 4 of a period:
  - o_load_pending rises and the current period still shows 3 high clks.
  - The next period shows 7 high clks.
  - o_load_pending drops at the boundary.
- i_ce strobed every 4th clk, P=4, D0=2, mode 0 -> o_pwm[0] high 8 of every 20 clks; i_load coinciding with a boundary is applied there with o_load_pending staying 0.
- Drop i_enable mid-period -> o_pwm all 0 within 2 clks, counter 0. Re-enable -> restarts at counter 0. Also pulse rst_n=0 mid-period -> all outputs 0 at the next edge and active registers cleared.

Source files
------------

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared period counter (edge- or center-aligned),
// per-channel duty compare, and double-buffered period/duty/mode swapped only at a period boundary or while idle.
module pwm_multi_channel #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_ce,
    input  logic                      i_enable,
    input  logic                      i_load,
    input  logic [WIDTH-1:0]          i_period,
    input  logic [CHANNELS*WIDTH-1:0] i_duty,
    input  logic                      i_mode,
    output logic [CHANNELS-1:0]       o_pwm,
    output logic                      o_period_end,
    output logic                      o_load_pending
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t                    state;
    logic [WIDTH-1:0]          cnt;
    logic [WIDTH-1:0]          period;
    logic [WIDTH-1:0]          shadow_period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic [CHANNELS*WIDTH-1:0] shadow_duty;
    logic                      mode;
    logic                      shadow_mode;
    logic                      pending;
    logic                      restart;
    logic                      boundary;
    logic                      turn_down;
    logic                      apply;
    logic [CHANNELS-1:0]       hit;

    // A boundary is the enabled tick that returns the counter to 0 in UP; center mode
    // with P=0 degenerates to a boundary on every tick.
    always_comb begin
        boundary  = 1'b0;
        turn_down = 1'b0;
        if (i_enable && i_ce) begin
            case (state)
                UP: begin
                    if (!mode) begin
                        boundary = (cnt >= period);
                    end else if (period == '0) begin
                        boundary = 1'b1;
                    end else begin
                        turn_down = (cnt >= period - ONE);
                    end
                end
                DOWN:    boundary = (cnt <= ONE);
                default: ;
            endcase
        end
    end

    assign apply = (state == IDLE) || boundary;

    always_comb begin
        hit = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            case (state)
                UP:      hit[k] = (cnt <  duty[k*WIDTH +: WIDTH]);
                DOWN:    hit[k] = (cnt <= duty[k*WIDTH +: WIDTH]);
                default: hit[k] = 1'b0;
            endcase
        end
    end

    // restart delays the boundary by one clk so o_period_end lines up with the
    // first registered compare of the new period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            period         <= '0;
            duty           <= '0;
            mode           <= 1'b0;
            shadow_period  <= '0;
            shadow_duty    <= '0;
            shadow_mode    <= 1'b0;
            pending        <= 1'b0;
            restart        <= 1'b0;
            o_pwm          <= '0;
            o_period_end   <= 1'b0;
            o_load_pending <= 1'b0;
        end else begin
            o_pwm        <= hit;
            restart      <= boundary;
            o_period_end <= restart;

            if (apply) begin
                if (i_load) begin
                    period <= i_period;
                    duty   <= i_duty;
                    mode   <= i_mode;
                end else if (pending) begin
                    period <= shadow_period;
                    duty   <= shadow_duty;
                    mode   <= shadow_mode;
                end
                pending        <= 1'b0;
                o_load_pending <= 1'b0;
            end else if (i_load) begin
                shadow_period  <= i_period;
                shadow_duty    <= i_duty;
                shadow_mode    <= i_mode;
                pending        <= 1'b1;
                o_load_pending <= 1'b1;
            end

            if (!i_enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= UP;
                        cnt   <= '0;
                    end
                    UP: begin
                        if (boundary) begin
                            cnt <= '0;
                        end else if (turn_down) begin
                            state <= DOWN;
                            cnt   <= period;
                        end else if (i_ce) begin
                            cnt <= cnt + ONE;
                        end
                    end
                    DOWN: begin
                        if (boundary) begin
                            state <= UP;
                            cnt   <= '0;
                        end else if (i_ce) begin
                            cnt <= cnt - ONE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: phase-based reference model compared every clk,
// directed scenarios with hand-computed expectations, then randomized stimulus.
module tb_pwm_multi_channel;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        enable;
    logic        load;
    logic [7:0]  period;
    logic [31:0] duty;
    logic        mode;
    logic [3:0]  pwm;
    logic        period_end;
    logic        load_pending;

    int passed = 0;
    int total  = 0;
    bit cmp_on = 1'b0;
    int ce_mode = 0;
    int ce_div  = 0;

    pwm_multi_channel #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ce          (ce),
        .i_enable      (enable),
        .i_load        (load),
        .i_period      (period),
        .i_duty        (duty),
        .i_mode        (mode),
        .o_pwm         (pwm),
        .o_period_end  (period_end),
        .o_load_pending(load_pending)
    );

    always #5 clk = ~clk;

    // Count-enable source: always on, every 4th clk, or random.
    always @(negedge clk) begin
        case (ce_mode)
            0:       ce = 1'b1;
            1: begin
                ce     = (ce_div == 0);
                ce_div = (ce_div + 1) % 4;
            end
            default: ce = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check_output(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: the period is a sequence of phase indices 0..len-1, and each
    // phase's output level follows directly from the edge/center rules.
    int   m_per, m_mode, m_ph;
    int   m_duty[4];
    int   s_per, s_mode;
    int   s_duty[4];
    bit   m_pend, m_run, pe_pipe, m_bnd;
    logic [3:0] m_lv;
    logic [3:0] exp_pwm;
    bit   exp_pe, exp_pend;

    function automatic int period_len(input int p, input int md);
        if (md == 0) return p + 1;
        if (p == 0) return 1;
        return 2 * p;
    endfunction

    function automatic bit level(input int ph, input int p, input int d, input int md);
        if (md == 0) return ph < d;
        if (p == 0) return d != 0;
        if (ph < p) return ph < d;
        return (2 * p - ph) <= d;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_per = 0; m_mode = 0; m_ph = 0; s_per = 0; s_mode = 0;
            for (int k = 0; k < 4; k++) begin
                m_duty[k] = 0;
                s_duty[k] = 0;
            end
            m_pend = 0; m_run = 0; pe_pipe = 0;
            exp_pwm = '0; exp_pe = 0; exp_pend = 0;
        end else begin
            for (int k = 0; k < 4; k++)
                m_lv[k] = m_run && level(m_ph, m_per, m_duty[k], m_mode);
            m_bnd   = m_run && enable && ce && (m_ph == period_len(m_per, m_mode) - 1);
            exp_pwm = m_lv;
            exp_pe  = pe_pipe;
            pe_pipe = m_bnd;
            if (!m_run || m_bnd) begin
                if (load) begin
                    m_per = int'(period); m_mode = int'(mode);
                    for (int k = 0; k < 4; k++) m_duty[k] = int'(duty[k*8 +: 8]);
                end else if (m_pend) begin
                    m_per = s_per; m_mode = s_mode;
                    for (int k = 0; k < 4; k++) m_duty[k] = s_duty[k];
                end
                m_pend = 0;
            end else if (load) begin
                s_per = int'(period); s_mode = int'(mode);
                for (int k = 0; k < 4; k++) s_duty[k] = int'(duty[k*8 +: 8]);
                m_pend = 1;
            end
            exp_pend = m_pend;
            if (!enable) begin
                m_run = 0; m_ph = 0;
            end else if (!m_run) begin
                m_run = 1; m_ph = 0;
            end else if (ce) begin
                m_ph = m_bnd ? 0 : m_ph + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check_output("pwm", int'(pwm), int'(exp_pwm));
            check_output("period_end", int'(period_end), int'(exp_pe));
            check_output("load_pending", int'(load_pending), int'(exp_pend));
        end
    end

    task automatic apply_stimulus(input int p, input logic [31:0] d, input bit md);
        period = 8'(p);
        duty   = d;
        mode   = md;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_applied();
        for (int i = 0; i < 400 && load_pending; i++) @(negedge clk);
        check_output("load_applied", int'(load_pending), 0);
    endtask

    task automatic wait_pe();
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (period_end) found = 1;
        end
        if (!found) check_output("pe_timeout", 0, 1);
    endtask

    task automatic count_window(input int n, output int hi0, output int hi1, output int hi2,
                                output int hi3, output int pe_n, output logic [63:0] pat0);
        hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; pe_n = 0; pat0 = '0;
        for (int i = 0; i < n; i++) begin
            hi0 += int'(pwm[0]);
            hi1 += int'(pwm[1]);
            hi2 += int'(pwm[2]);
            hi3 += int'(pwm[3]);
            pe_n += int'(period_end);
            if (i < 64) pat0[i] = pwm[0];
            @(negedge clk);
        end
    endtask

    int h0, h1, h2, h3, pn;
    logic [63:0] pat;

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; period = '0; duty = '0; mode = 1'b0;
        @(posedge clk);
        cmp_on = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset_pwm", int'(pwm), 0);
        check_output("reset_pe", int'(period_end), 0);
        check_output("reset_pending", int'(load_pending), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] edge mode P=9");
        apply_stimulus(9, {8'd255, 8'd10, 8'd0, 8'd3}, 1'b0);
        check_output("idle_load_pending", int'(load_pending), 0);
        enable = 1'b1;
        wait_pe();
        count_window(20, h0, h1, h2, h3, pn, pat);
        check_output("edge_hi0", h0, 6);
        check_output("edge_pe", pn, 2);
        check_output("edge_d0_zero", h1, 0);
        check_output("edge_d_p1", h2, 20);
        check_output("edge_d_max", h3, 20);
        check_output("edge_pattern", int'(pat[9:0]), 10'b0000000111);

        $display("[TB] center mode P=8");
        apply_stimulus(8, {8'd255, 8'd10, 8'd0, 8'd3}, 1'b1);
        wait_applied();
        wait_pe();
        count_window(32, h0, h1, h2, h3, pn, pat);
        check_output("center_hi0", h0, 12);
        check_output("center_pe", pn, 2);
        check_output("center_pattern", int'(pat[15:0]), 16'hE007);
        apply_stimulus(8, {8'd255, 8'd10, 8'd0, 8'd8}, 1'b1);
        wait_applied();
        wait_pe();
        count_window(16, h0, h1, h2, h3, pn, pat);
        check_output("center_full", h0, 16);

        $display("[TB] mid-period load");
        apply_stimulus(9, {8'd255, 8'd10, 8'd0, 8'd3}, 1'b0);
        wait_applied();
        wait_pe();
        h0 = 0;
        for (int i = 0; i < 10; i++) begin
            h0 += int'(pwm[0]);
            if (i == 4) begin
                duty = {8'd255, 8'd10, 8'd0, 8'd7};
                load = 1'b1;
            end
            if (i == 5) begin
                load = 1'b0;
                check_output("mid_pending_set", int'(load_pending), 1);
            end
            if (i == 9) check_output("mid_pending_clear", int'(load_pending), 0);
            @(negedge clk);
        end
        check_output("mid_old_hi", h0, 3);
        check_output("mid_new_pe", int'(period_end), 1);
        count_window(10, h0, h1, h2, h3, pn, pat);
        check_output("mid_new_hi", h0, 7);

        $display("[TB] strobed ce P=4");
        ce_mode = 1;
        apply_stimulus(4, {8'd255, 8'd10, 8'd0, 8'd2}, 1'b0);
        wait_applied();
        wait_pe();
        count_window(40, h0, h1, h2, h3, pn, pat);
        check_output("strobe_hi0", h0, 16);
        check_output("strobe_pe", pn, 2);
        repeat (18) @(negedge clk);
        duty = {8'd255, 8'd10, 8'd0, 8'd4};
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_output("bypass_pending", int'(load_pending), 0);
        @(negedge clk);
        check_output("bypass_pe", int'(period_end), 1);
        check_output("bypass_pending2", int'(load_pending), 0);
        count_window(20, h0, h1, h2, h3, pn, pat);
        check_output("bypass_hi0", h0, 16);

        $display("[TB] enable drop and restart");
        ce_mode = 0;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check_output("disable_pwm", int'(pwm), 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        count_window(5, h0, h1, h2, h3, pn, pat);
        check_output("restart_pattern", int'(pat[4:0]), 5'b01111);

        $display("[TB] reset mid-period");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midrst_pwm", int'(pwm), 0);
        check_output("midrst_pe", int'(period_end), 0);
        check_output("midrst_pending", int'(load_pending), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        count_window(4, h0, h1, h2, h3, pn, pat);
        check_output("cleared_pe", pn, 4);
        check_output("cleared_hi", h0 + h1 + h2 + h3, 0);

        $display("[TB] random stimulus");
        ce_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            rst_n  = ($urandom_range(0, 999) != 0);
            enable = ($urandom_range(0, 99) < 95);
            load   = ($urandom_range(0, 99) < 6);
            mode   = 1'($urandom_range(0, 1));
            period = ($urandom_range(0, 99) < 80) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            for (int k = 0; k < 4; k++)
                duty[k*8 +: 8] = ($urandom_range(0, 99) < 80) ? 8'($urandom_range(0, 14)) : 8'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
